mcp_n_xfer: RTL and testbench

- Single-clock, multi-channel multi-cycle-path (MCP) transfer block and parametrised successor to the 8-bit single-channel mcp_1.
- Arbitrates CHANNELS request ports round-robin and launches the granted word onto an internal launch register held stable for exactly MCP_CYCLES clocks.
- Captures that word into the output register and presents it with a valid/ready handshake.
- Sits between producer logic and a slow-settling consumer path that static timing constrains as MCP_CYCLES-cycle multicycle.

---
 rtl/mcp_pkg.sv | 17 +
 rtl/mcp_rr_arb.sv | 35 +++
 rtl/mcp_n_xfer.sv | 127 ++++++++++++
 tb/tb_mcp_n_xfer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mcp_pkg.sv
// Shared types and constants for the multi-channel multicycle-path transfer block.
package mcp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    OUT
  } mcp_state_t;

  localparam int MCP_MIN_CYCLES = 2;

  // Channel index needs at least one bit even when only one channel exists.
  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/mcp_rr_arb.sv
// Combinational round-robin arbiter: searches upward from pointer+1 with wrap
// and returns a one-hot grant plus the encoded winner.
module mcp_rr_arb
  import mcp_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]         req,
  input  logic [chan_w(CHANNELS)-1:0] pointer,
  input  logic                        enable,
  output logic [CHANNELS-1:0]         grant,
  output logic [chan_w(CHANNELS)-1:0] index
);

  localparam int IDX_W = chan_w(CHANNELS);

  int   pos;
  logic found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      pos = (int'(pointer) + i) % CHANNELS;
      if (enable && !found && req[pos]) begin
        grant[pos] = 1'b1;
        index      = IDX_W'(pos);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcp_n_xfer.sv
// Multi-channel MCP transfer: arbitrates a word into a launch register that stays
// frozen for MCP_CYCLES clocks, then captures it into a valid/ready output.
module mcp_n_xfer
  import mcp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int MCP_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS*WIDTH-1:0]   data_in,
  input  logic [CHANNELS-1:0]         in_valid,
  output logic [CHANNELS-1:0]         in_ready,
  output logic [WIDTH-1:0]            data_out,
  output logic [chan_w(CHANNELS)-1:0] out_chan,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic [CNT_W-1:0]            xfer_count
);

  localparam int IDX_W = chan_w(CHANNELS);
  localparam int HC_W  = $clog2(MCP_CYCLES);
  localparam logic [HC_W-1:0]  HOLD_INIT = HC_W'(MCP_CYCLES - 1);
  localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(CHANNELS - 1);

  if (MCP_CYCLES < MCP_MIN_CYCLES) begin : g_mcp_check
    $error("mcp_n_xfer: MCP_CYCLES must be at least %0d", MCP_MIN_CYCLES);
  end

  mcp_state_t         state, state_next;
  logic [WIDTH-1:0]   launch_reg;
  logic [IDX_W-1:0]   chan_reg;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [HC_W-1:0]    cnt;
  logic [CHANNELS-1:0] grant;
  logic               arb_en;
  logic               launch;
  logic               capture;
  logic               handshake;

  assign arb_en = (state == IDLE) && !reset;

  mcp_rr_arb #(
    .CHANNELS(CHANNELS)
  ) u_arb (
    .req    (in_valid),
    .pointer(ptr),
    .enable (arb_en),
    .grant  (grant),
    .index  (grant_idx)
  );

  assign in_ready = grant;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The count runs down to zero so the capture edge lands MCP_CYCLES edges after launch.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (|grant) begin
          launch     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Launch register only moves on a launch edge; the multicycle constraint depends on it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      launch_reg <= '0;
      chan_reg   <= '0;
      ptr        <= PTR_INIT;
      cnt        <= '0;
    end else if (launch) begin
      launch_reg <= data_in[grant_idx*WIDTH +: WIDTH];
      chan_reg   <= grant_idx;
      ptr        <= grant_idx;
      cnt        <= HOLD_INIT;
    end else if (state == HOLD) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      out_chan   <= '0;
      out_valid  <= 1'b0;
      xfer_count <= '0;
    end else if (capture) begin
      data_out  <= launch_reg;
      out_chan  <= chan_reg;
      out_valid <= 1'b1;
    end else if (handshake) begin
      out_valid  <= 1'b0;
      xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mcp_n_xfer.sv
// Self-checking bench for mcp_n_xfer: directed scenarios plus random traffic,
// compared each cycle against a transaction-level model of the transfer rules.
module tb_mcp_n_xfer;

  localparam int WIDTH      = 8;
  localparam int CHANNELS   = 4;
  localparam int MCP_CYCLES = 3;
  localparam int CNT_W      = 5;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          data_out;
  logic [1:0]                out_chan;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic [CNT_W-1:0]          xfer_count;

  // A narrow counter lets the wrap happen within a short run.
  mcp_n_xfer #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MCP_CYCLES(MCP_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  logic [CHANNELS-1:0] ready_seen;

  bit             m_inflight;
  int             m_age;
  logic [WIDTH-1:0] m_word;
  int             m_chan;
  int             m_ptr;
  bit             m_valid;
  logic [WIDTH-1:0] m_data_out;
  int             m_out_chan;
  int             m_count;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  function automatic int pickChannel(input logic [CHANNELS-1:0] req, input int after);
    for (int i = 1; i <= CHANNELS; i++) begin
      if (req[(after + i) % CHANNELS]) return (after + i) % CHANNELS;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_inflight = 0;
    m_age      = 0;
    m_word     = '0;
    m_chan     = 0;
    m_ptr      = CHANNELS - 1;
    m_valid    = 0;
    m_data_out = '0;
    m_out_chan = 0;
    m_count    = 0;
  endtask

  // One clock edge of the transfer rules: handshake, else grant, else age the held word.
  task automatic modelEdge();
    int g;
    if (m_valid && out_ready) begin
      m_valid    = 0;
      m_inflight = 0;
      m_count    = (m_count + 1) % (1 << CNT_W);
    end else if (!m_inflight) begin
      g = pickChannel(in_valid, m_ptr);
      if (g >= 0) begin
        m_inflight = 1;
        m_age      = 0;
        m_word     = data_in[g*WIDTH +: WIDTH];
        m_chan     = g;
        m_ptr      = g;
      end
    end else if (!m_valid) begin
      m_age++;
      if (m_age == MCP_CYCLES) begin
        m_valid    = 1;
        m_data_out = m_word;
        m_out_chan = m_chan;
      end
    end
  endtask

  task automatic checkCycle();
    int g;
    logic [CHANNELS-1:0] exp_ready;
    g = (m_inflight || reset) ? -1 : pickChannel(in_valid, m_ptr);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    ready_seen = in_ready;
    checkOutput("in_ready",   32'(in_ready),   32'(exp_ready));
    checkOutput("out_valid",  32'(out_valid),  32'(m_valid));
    checkOutput("data_out",   32'(data_out),   32'(m_data_out));
    checkOutput("out_chan",   32'(out_chan),   32'(m_out_chan));
    checkOutput("busy",       32'(busy),       32'(m_inflight));
    checkOutput("xfer_count", 32'(xfer_count), 32'(m_count));
  endtask

  task automatic applyStimulus(input logic [CHANNELS-1:0] valid, input logic [CHANNELS*WIDTH-1:0] data,
                               input logic ordy, input logic rst);
    @(negedge clk);
    in_valid  = valid;
    data_in   = data;
    out_ready = ordy;
    reset     = rst;
    if (rst) modelReset();
    #1;
    checkCycle();
    @(posedge clk);
    if (!rst) modelEdge();
    cycle++;
  endtask

  initial begin
    int last_grant;
    logic [CHANNELS-1:0] rv;
    reset     = 1'b1;
    in_valid  = '0;
    data_in   = '0;
    out_ready = 1'b0;
    modelReset();

    repeat (2) applyStimulus('0, '0, 1'b1, 1'b1);

    $display("[TB] single transfer on ch0");
    applyStimulus(4'b0001, 32'h000000A5, 1'b1, 1'b0);
    checkOutput("first_grant", 32'(ready_seen), 32'h1);
    repeat (6) applyStimulus('0, 32'h000000A5, 1'b1, 1'b0);
    checkOutput("count_after_first", 32'(xfer_count), 32'd1);

    $display("[TB] four channels round-robin");
    applyStimulus('0, '0, 1'b1, 1'b1);
    last_grant = -1;
    for (int k = 0; k < 27; k++) begin
      applyStimulus(4'hF, 32'h43322110, 1'b1, 1'b0);
      if (|ready_seen) begin
        if (last_grant >= 0) checkOutput("launch_gap", 32'(cycle - last_grant), 32'd5);
        last_grant = cycle;
      end
    end
    repeat (8) applyStimulus('0, '0, 1'b1, 1'b0);

    $display("[TB] stalled consumer on ch2");
    applyStimulus(4'b0100, 32'h005A0000, 1'b0, 1'b0);
    repeat (14) applyStimulus(4'b0010, 32'h00000000, 1'b0, 1'b0);
    repeat (8) applyStimulus(4'b0010, 32'h00000000, 1'b1, 1'b0);
    repeat (6) applyStimulus('0, '0, 1'b1, 1'b0);

    $display("[TB] data change during hold");
    applyStimulus('0, '0, 1'b1, 1'b1);
    applyStimulus(4'b0001, 32'h00000011, 1'b1, 1'b0);
    repeat (6) applyStimulus('0, 32'h000000FF, 1'b1, 1'b0);

    $display("[TB] reset during hold");
    applyStimulus(4'b0010, 32'h00007700, 1'b1, 1'b0);
    applyStimulus('0, 32'h00007700, 1'b1, 1'b0);
    applyStimulus('0, 32'h00007700, 1'b1, 1'b1);
    applyStimulus(4'hF, 32'h44332211, 1'b1, 1'b0);
    checkOutput("grant_after_reset", 32'(ready_seen), 32'h1);
    repeat (6) applyStimulus('0, '0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int k = 0; k < 3000; k++) begin
      rv = ($urandom_range(0, 3) == 0) ? '0 : CHANNELS'($urandom);
      applyStimulus(rv, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
    end
    applyStimulus('0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
